// File: rtl/mac_tx_gate_sched_pkg.sv
// Shared types and constants for the time-aware MAC TX gate scheduler.
// Speed codes, wire overhead, ptr-word layout and FSM states.
package mac_tx_gate_sched_pkg;

    localparam logic [1:0] SPD_10M   = 2'b00;
    localparam logic [1:0] SPD_100M  = 2'b01;
    localparam logic [1:0] SPD_1000M = 2'b10;

    localparam int OVHD_BYTES = 24;
    localparam int PTR_W      = 16;
    localparam int LEN_LSB    = 0;
    localparam int LEN_MAX    = 1518;
    localparam int TX_W       = 21;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_GRANT,
        ST_BUSY
    } state_t;

endpackage

// File: rtl/mac_tx_gate_sched_phase_cnt.sv
// Schedule phase tracker: follows the ns timebase and wraps each cycle.
// Holds a shadow copy of the window config, refreshed at every wrap.
module mac_tx_phase_cnt
    import mac_tx_gate_sched_pkg::*;
#(
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      counter_ns,
    input  logic [CYC_W-1:0] cfg_cycle_ns,
    input  logic [CYC_W-1:0] cfg_open_ns,
    input  logic [CYC_W-1:0] cfg_close_ns,
    output logic             in_win,
    output logic [CYC_W-1:0] t_open
);

    logic [31:0]      prev_ns;
    logic [CYC_W-1:0] phase;
    logic [CYC_W-1:0] cyc_s;
    logic [CYC_W-1:0] open_s;
    logic [CYC_W-1:0] close_s;
    logic [31:0]      delta;
    logic [CYC_W:0]   sum;
    logic             wrap;

    assign delta = counter_ns - prev_ns;
    assign sum   = {1'b0, phase} + (CYC_W+1)'(delta);
    assign wrap  = sum >= {1'b0, cyc_s};

    always_ff @(posedge clk) begin
        prev_ns <= counter_ns;
        if (rst) begin
            phase   <= '0;
            cyc_s   <= cfg_cycle_ns;
            open_s  <= cfg_open_ns;
            close_s <= cfg_close_ns;
        end else if (wrap) begin
            phase   <= CYC_W'(sum - {1'b0, cyc_s});
            cyc_s   <= cfg_cycle_ns;
            open_s  <= cfg_open_ns;
            close_s <= cfg_close_ns;
        end else begin
            phase <= sum[CYC_W-1:0];
        end
    end

    assign in_win = (phase >= open_s) && (phase < close_s);
    // Time left until the next window opens, possibly in the next cycle.
    assign t_open = (phase < open_s) ? (open_s - phase)
                                     : (cyc_s - phase + open_s);

endmodule

// File: rtl/mac_tx_gate_sched.sv
// Time-aware TX scheduler: grants one BE or TT frame at a time to the MAC.
// TT only inside its window; BE only if it finishes before the window opens.
module mac_tx_gate_sched
    import mac_tx_gate_sched_pkg::*;
#(
    parameter int CYC_W  = 32,
    parameter int LEN_W  = 11,
    parameter int OVHD_B = OVHD_BYTES,
    parameter int STAT_W = 16
) (
    input  logic              sys_clk,
    input  logic              rst_sys,
    input  logic [1:0]        speed,
    input  logic [31:0]       counter_ns,
    input  logic              cfg_en,
    input  logic [CYC_W-1:0]  cfg_cycle_ns,
    input  logic [CYC_W-1:0]  cfg_open_ns,
    input  logic [CYC_W-1:0]  cfg_close_ns,
    input  logic              be_ptr_empty,
    input  logic [PTR_W-1:0]  be_ptr_din,
    output logic              be_ptr_rd,
    input  logic              tt_ptr_empty,
    input  logic [PTR_W-1:0]  tt_ptr_din,
    output logic              tt_ptr_rd,
    output logic              grant_valid,
    output logic              grant_sel,
    output logic [PTR_W-1:0]  grant_ptr,
    input  logic              grant_ready,
    input  logic              frame_done,
    output logic [STAT_W-1:0] guard_hold_cnt
);

    localparam logic [LEN_W-1:0] LEN_CAP = LEN_W'(LEN_MAX);

    state_t           state;
    logic [PTR_W-1:0] be_head;
    logic [PTR_W-1:0] tt_head;
    logic             be_vld;
    logic             tt_vld;
    logic [TX_W-1:0]  tx_ns;

    logic             in_win;
    logic [CYC_W-1:0] t_open;

    logic [LEN_W-1:0] len_raw;
    logic [LEN_W-1:0] len_g;
    logic [TX_W-1:0]  wire_b;
    logic [TX_W-1:0]  tx_calc;
    logic             guard_ok;
    logic             tt_elig;
    logic             be_elig;
    logic             guard_blk;
    logic             accept;

    mac_tx_phase_cnt #(
        .CYC_W(CYC_W)
    ) u_phase (
        .clk         (sys_clk),
        .rst         (rst_sys),
        .counter_ns  (counter_ns),
        .cfg_cycle_ns(cfg_cycle_ns),
        .cfg_open_ns (cfg_open_ns),
        .cfg_close_ns(cfg_close_ns),
        .in_win      (in_win),
        .t_open      (t_open)
    );

    // Malformed lengths are costed as a full-size frame.
    assign len_raw = be_ptr_din[LEN_LSB +: LEN_W];
    assign len_g   = (len_raw == '0 || len_raw > LEN_CAP) ? LEN_CAP : len_raw;
    assign wire_b  = TX_W'(len_g) + TX_W'(OVHD_B);

    always_comb begin
        case (speed)
            SPD_10M:   tx_calc = (wire_b << 9) + (wire_b << 8) + (wire_b << 5);
            SPD_100M:  tx_calc = (wire_b << 6) + (wire_b << 4);
            SPD_1000M: tx_calc = wire_b << 3;
            default:   tx_calc = wire_b << 3;
        endcase
    end

    assign guard_ok  = CYC_W'(tx_ns) <= t_open;
    assign tt_elig   = tt_vld && (in_win || !cfg_en);
    assign be_elig   = be_vld && (!cfg_en || (!in_win && guard_ok));
    assign guard_blk = be_vld && cfg_en && !in_win && !guard_ok;

    assign accept    = grant_valid && grant_ready && !rst_sys;
    assign be_ptr_rd = accept && !grant_sel;
    assign tt_ptr_rd = accept && grant_sel;

    always_ff @(posedge sys_clk) begin
        if (rst_sys) begin
            state          <= ST_IDLE;
            be_head        <= '0;
            tt_head        <= '0;
            be_vld         <= 1'b0;
            tt_vld         <= 1'b0;
            tx_ns          <= '0;
            grant_valid    <= 1'b0;
            grant_sel      <= 1'b0;
            grant_ptr      <= '0;
            guard_hold_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!be_ptr_empty || !tt_ptr_empty) begin
                        be_head <= be_ptr_din;
                        tt_head <= tt_ptr_din;
                        be_vld  <= !be_ptr_empty;
                        tt_vld  <= !tt_ptr_empty;
                        tx_ns   <= tx_calc;
                        state   <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (tt_elig) begin
                        grant_valid <= 1'b1;
                        grant_sel   <= 1'b1;
                        grant_ptr   <= tt_head;
                        state       <= ST_GRANT;
                    end else if (be_elig) begin
                        grant_valid <= 1'b1;
                        grant_sel   <= 1'b0;
                        grant_ptr   <= be_head;
                        state       <= ST_GRANT;
                    end else begin
                        state <= ST_IDLE;
                        if (guard_blk && guard_hold_cnt != '1) begin
                            guard_hold_cnt <= guard_hold_cnt + 1'b1;
                        end
                    end
                end
                ST_GRANT: begin
                    if (grant_ready) begin
                        grant_valid <= 1'b0;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (frame_done) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_gate_sched.sv
// Directed + randomized bench for mac_tx_gate_sched with a phase/eligibility
// reference model and simple array-backed FWFT pointer FIFOs.
module tb_mac_tx_gate_sched;

    logic        sys_clk = 1'b0;
    logic        rst_sys;
    logic [1:0]  speed;
    logic [31:0] counter_ns = 32'hFFFF_F000;
    logic        cfg_en;
    logic [31:0] cfg_cycle_ns;
    logic [31:0] cfg_open_ns;
    logic [31:0] cfg_close_ns;
    logic        be_ptr_empty;
    logic [15:0] be_ptr_din;
    logic        be_ptr_rd;
    logic        tt_ptr_empty;
    logic [15:0] tt_ptr_din;
    logic        tt_ptr_rd;
    logic        grant_valid;
    logic        grant_sel;
    logic [15:0] grant_ptr;
    logic        grant_ready;
    logic        frame_done;
    logic [15:0] guard_hold_cnt;

    int checks   = 0;
    int failures = 0;

    logic [15:0] be_mem [0:63];
    logic [15:0] tt_mem [0:63];
    logic [7:0]  be_wr = 8'd0;
    logic [7:0]  tt_wr = 8'd0;
    logic [7:0]  be_rd_n = 8'd0;
    logic [7:0]  tt_rd_n = 8'd0;
    logic [31:0] step = 32'd0;
    logic [31:0] jump = 32'd0;
    logic [31:0] last_cnt = 32'd0;
    logic [31:0] base = 32'd0;

    mac_tx_gate_sched dut (
        .sys_clk       (sys_clk),
        .rst_sys       (rst_sys),
        .speed         (speed),
        .counter_ns    (counter_ns),
        .cfg_en        (cfg_en),
        .cfg_cycle_ns  (cfg_cycle_ns),
        .cfg_open_ns   (cfg_open_ns),
        .cfg_close_ns  (cfg_close_ns),
        .be_ptr_empty  (be_ptr_empty),
        .be_ptr_din    (be_ptr_din),
        .be_ptr_rd     (be_ptr_rd),
        .tt_ptr_empty  (tt_ptr_empty),
        .tt_ptr_din    (tt_ptr_din),
        .tt_ptr_rd     (tt_ptr_rd),
        .grant_valid   (grant_valid),
        .grant_sel     (grant_sel),
        .grant_ptr     (grant_ptr),
        .grant_ready   (grant_ready),
        .frame_done    (frame_done),
        .guard_hold_cnt(guard_hold_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    assign be_ptr_empty = (be_wr == be_rd_n);
    assign tt_ptr_empty = (tt_wr == tt_rd_n);
    assign be_ptr_din   = be_mem[be_rd_n[5:0]];
    assign tt_ptr_din   = tt_mem[tt_rd_n[5:0]];

    always @(posedge sys_clk) begin
        if (be_ptr_rd) be_rd_n <= be_rd_n + 8'd1;
        if (tt_ptr_rd) tt_rd_n <= tt_rd_n + 8'd1;
        counter_ns <= counter_ns + step + jump;
        last_cnt   <= counter_ns;
        if (rst_sys) base <= counter_ns;
    end

    // Phase seen by the DUT: elapsed ns since reset, modulo the cycle.
    function automatic logic [31:0] mphase();
        logic [31:0] d;
        d = last_cnt - base;
        return d % cfg_cycle_ns;
    endfunction

    function automatic bit m_in_win(input logic [31:0] p);
        return (p >= cfg_open_ns) && (p < cfg_close_ns);
    endfunction

    function automatic longint m_topen(input logic [31:0] p);
        if (p < cfg_open_ns) return longint'(cfg_open_ns) - longint'(p);
        return longint'(cfg_cycle_ns) - longint'(p) + longint'(cfg_open_ns);
    endfunction

    function automatic longint m_tx(input logic [1:0] spd, input int len);
        longint l;
        longint nsb;
        l = (len == 0 || len > 1518) ? 1518 : len;
        nsb = (spd == 2'b00) ? 800 : (spd == 2'b01) ? 80 : 8;
        return (l + 24) * nsb;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_be(input logic [15:0] v);
        be_mem[be_wr[5:0]] = v;
        be_wr = be_wr + 8'd1;
    endtask

    task automatic push_tt(input logic [15:0] v);
        tt_mem[tt_wr[5:0]] = v;
        tt_wr = tt_wr + 8'd1;
    endtask

    task automatic goto_phase(input logic [31:0] p);
        logic [31:0] q;
        q = mphase();
        jump = 32'((64'(p) + 64'(cfg_cycle_ns) - 64'(q)) % 64'(cfg_cycle_ns));
        @(negedge sys_clk);
        jump = 32'd0;
        @(negedge sys_clk);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (grant_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        if (!ok) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic serve(input bit sel, input logic [15:0] ptr,
                         input int budget, input int hold);
        bit ok;
        logic [7:0] b0;
        logic [7:0] t0;
        wait_valid(budget, ok);
        if (!ok) return;
        chk("grant_sel", 32'(grant_sel), 32'(sel));
        chk("grant_ptr", 32'(grant_ptr), 32'(ptr));
        b0 = be_rd_n;
        t0 = tt_rd_n;
        for (int i = 0; i < hold; i++) begin
            @(negedge sys_clk);
            chk("hold_valid", 32'(grant_valid), 32'd1);
            chk("hold_ptr", 32'(grant_ptr), 32'(ptr));
            chk("hold_nopop", 32'({be_ptr_rd, tt_ptr_rd}), 32'd0);
        end
        grant_ready = 1'b1;
        #1;
        chk("pop_pulse", 32'({be_ptr_rd, tt_ptr_rd}), sel ? 32'd1 : 32'd2);
        @(negedge sys_clk);
        grant_ready = 1'b0;
        chk("valid_drop", 32'(grant_valid), 32'd0);
        chk("be_pops", 32'(8'(be_rd_n - b0)), sel ? 32'd0 : 32'd1);
        chk("tt_pops", 32'(8'(tt_rd_n - t0)), sel ? 32'd1 : 32'd0);
        frame_done = 1'b1;
        @(negedge sys_clk);
        frame_done = 1'b0;
    endtask

    task automatic drain();
        cfg_en = 1'b0;
        while (be_wr != be_rd_n || tt_wr != tt_rd_n) begin
            if (tt_wr != tt_rd_n) serve(1'b1, tt_mem[tt_rd_n[5:0]], 10, 0);
            else serve(1'b0, be_mem[be_rd_n[5:0]], 10, 0);
        end
        cfg_en = 1'b1;
    endtask

    initial begin
        bit          ok;
        logic [7:0]  b0;
        logic [31:0] ph;
        logic [15:0] g0;

        for (int i = 0; i < 64; i++) begin
            be_mem[i] = 16'h0;
            tt_mem[i] = 16'h0;
        end
        rst_sys = 1'b1;
        speed = 2'b10;
        cfg_en = 1'b1;
        cfg_cycle_ns = 32'd100000;
        cfg_open_ns = 32'd50000;
        cfg_close_ns = 32'd60000;
        grant_ready = 1'b0;
        frame_done = 1'b0;
        repeat (3) @(negedge sys_clk);
        rst_sys = 1'b0;
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_sel", 32'(grant_sel), 32'd0);
        chk("rst_ptr", 32'(grant_ptr), 32'd0);
        chk("rst_be_rd", 32'(be_ptr_rd), 32'd0);
        chk("rst_tt_rd", 32'(tt_ptr_rd), 32'd0);
        chk("rst_guard", 32'(guard_hold_cnt), 32'd0);

        // Gating off: plain TT-over-BE priority, no window or guard.
        cfg_en = 1'b0;
        push_tt({5'd1, 11'd60});
        push_be({5'd2, 11'd60});
        serve(1'b1, {5'd1, 11'd60}, 4, 0);
        serve(1'b0, {5'd2, 11'd60}, 6, 0);
        cfg_en = 1'b1;

        // BE 1514B at phase 30000 fits before the window.
        goto_phase(32'd30000);
        push_be({5'd3, 11'd1514});
        repeat (2) @(negedge sys_clk);
        chk("guard_fit_valid", 32'(grant_valid), 32'd1);
        serve(1'b0, {5'd3, 11'd1514}, 1, 0);

        // BE 1514B at phase 40000 would overrun the window opening.
        goto_phase(32'd40000);
        push_be({5'd4, 11'd1514});
        repeat (2) @(negedge sys_clk);
        chk("guard_hold_valid", 32'(grant_valid), 32'd0);
        chk("guard_hold_cnt", 32'(guard_hold_cnt), 32'd1);
        step = 32'd100;
        wait_valid(1000, ok);
        if (ok) chk("be_after_win", 32'(mphase() >= 32'd60000), 32'd1);
        serve(1'b0, {5'd4, 11'd1514}, 1, 0);
        step = 32'd0;

        // TT waits for its window, then grants within two cycles.
        goto_phase(32'd10000);
        push_tt({5'd5, 11'd100});
        repeat (2) @(negedge sys_clk);
        chk("tt_early", 32'(grant_valid), 32'd0);
        step = 32'd100;
        wait_valid(1000, ok);
        if (ok) begin
            ph = mphase();
            chk("tt_open_min", 32'(ph >= 32'd50000), 32'd1);
            chk("tt_open_lat", 32'(ph <= 32'd50200), 32'd1);
        end
        serve(1'b1, {5'd5, 11'd100}, 1, 10);
        step = 32'd0;

        // Reset while a grant is offered: no pop, grant dropped.
        goto_phase(32'd70000);
        push_be({5'd6, 11'd200});
        wait_valid(4, ok);
        b0 = be_rd_n;
        grant_ready = 1'b1;
        rst_sys = 1'b1;
        #1;
        chk("rstg_nopop", 32'(be_ptr_rd), 32'd0);
        @(negedge sys_clk);
        rst_sys = 1'b0;
        grant_ready = 1'b0;
        chk("rstg_drop", 32'(grant_valid), 32'd0);
        chk("rstg_fifo", 32'(8'(be_rd_n - b0)), 32'd0);
        chk("rstg_guard", 32'(guard_hold_cnt), 32'd0);
        serve(1'b0, {5'd6, 11'd200}, 4, 0);

        // Reset while the MAC is busy with an accepted frame.
        push_be({5'd7, 11'd300});
        wait_valid(4, ok);
        grant_ready = 1'b1;
        @(negedge sys_clk);
        grant_ready = 1'b0;
        b0 = be_rd_n;
        rst_sys = 1'b1;
        @(negedge sys_clk);
        rst_sys = 1'b0;
        chk("rstb_valid", 32'(grant_valid), 32'd0);
        chk("rstb_sel_ptr", 32'({grant_sel, grant_ptr}), 32'd0);
        chk("rstb_rd", 32'({be_ptr_rd, tt_ptr_rd}), 32'd0);
        chk("rstb_fifo", 32'(8'(be_rd_n - b0)), 32'd0);
        push_be({5'd8, 11'd64});
        serve(1'b0, {5'd8, 11'd64}, 4, 0);

        // Randomized eligibility against the reference rules.
        for (int t = 0; t < 40; t++) begin
            logic [1:0]  spd;
            logic [31:0] p;
            int          mode;
            int          lenb;
            int          lent;
            logic [15:0] pb;
            logic [15:0] pt;
            bit          hb;
            bit          ht;
            bit          iw;
            bit          te;
            bit          bee;
            bit          inc;
            spd = 2'($urandom_range(0, 3));
            speed = spd;
            p = $urandom_range(0, 99999);
            goto_phase(p);
            mode = int'($urandom_range(1, 3));
            hb = mode[0];
            ht = mode[1];
            lenb = int'($urandom_range(0, 2047));
            lent = int'($urandom_range(1, 1518));
            pb = {5'($urandom()), 11'(lenb)};
            pt = {5'($urandom()), 11'(lent)};
            iw = m_in_win(p);
            te = ht && iw;
            bee = hb && !iw && (m_tx(spd, lenb) <= m_topen(p));
            inc = !te && !bee && hb && !iw;
            g0 = guard_hold_cnt;
            if (ht) push_tt(pt);
            if (hb) push_be(pb);
            repeat (2) @(negedge sys_clk);
            chk("rnd_valid", 32'(grant_valid), 32'(te || bee));
            chk("rnd_guard", 32'(16'(guard_hold_cnt - g0)), 32'(inc));
            if (te) serve(1'b1, pt, 1, 0);
            else if (bee) serve(1'b0, pb, 1, 0);
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
